// File: rtl/issue_stage_pkg.sv
// Shared constants and types for the operand-fetch / issue stage.
package issue_stage_pkg;

    localparam int DEFAULT_DATA_WIDTH     = 32;
    localparam int DEFAULT_REG_ADDR_WIDTH = 5;
    localparam int DEFAULT_EXE_LATENCY    = 2;

    // Instruction class driven into execution when nothing is issued.
    localparam logic [6:0] NOP_INSTR_TYPE = 7'd0;

    // Control fields forwarded unchanged from decode into execution.
    typedef struct packed {
        logic [6:0]  instruction_type;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [20:0] immediate;
    } issue_ctrl_t;

endpackage

// File: rtl/issue_scoreboard.sv
// Per-register busy bits plus a destination tag pipe whose depth matches the
// execution latency. The pipe head retires one tag per cycle.
module issue_scoreboard
    import issue_stage_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = DEFAULT_REG_ADDR_WIDTH,
    parameter int EXE_LATENCY    = DEFAULT_EXE_LATENCY
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      set_valid,
    input  logic [REG_ADDR_WIDTH-1:0] set_rd,
    input  logic [REG_ADDR_WIDTH-1:0] query_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] query_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] query_rd,
    output logic                      head_valid,
    output logic [REG_ADDR_WIDTH-1:0] head_rd,
    output logic                      hazard
);

    localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;

    logic [NUM_REGS-1:0]       busy_q;
    logic [NUM_REGS-1:0]       busy_d;
    logic [NUM_REGS-1:0]       busy_clr;
    logic [NUM_REGS-1:0]       busy_eff;
    logic [EXE_LATENCY-1:0]    tag_valid_q;
    logic [EXE_LATENCY-1:0]    tag_valid_d;
    logic [REG_ADDR_WIDTH-1:0] tag_rd_q [EXE_LATENCY];
    logic [REG_ADDR_WIDTH-1:0] tag_rd_d [EXE_LATENCY];

    assign head_valid = tag_valid_q[EXE_LATENCY-1];
    assign head_rd    = tag_rd_q[EXE_LATENCY-1];

    // Tag pipe advances every cycle; execution never stalls, so neither does this.
    always_comb begin
        tag_valid_d[0] = set_valid;
        tag_rd_d[0]    = set_rd;
        for (int i = 1; i < EXE_LATENCY; i++) begin
            tag_valid_d[i] = tag_valid_q[i-1];
            tag_rd_d[i]    = tag_rd_q[i-1];
        end
    end

    // Retiring head clears its busy bit this cycle; a new issue to the same index wins.
    always_comb begin
        busy_clr = '0;
        if (head_valid) begin
            busy_clr[head_rd] = 1'b1;
        end
        busy_eff = busy_q & ~busy_clr;
        busy_d   = busy_eff;
        if (set_valid && set_rd != '0) begin
            busy_d[set_rd] = 1'b1;
        end
    end

    // rs2 is checked even for immediate forms; the extra stall is accepted.
    assign hazard = (query_rs1 != '0 && busy_eff[query_rs1]) ||
                    (query_rs2 != '0 && busy_eff[query_rs2]) ||
                    (query_rd  != '0 && busy_eff[query_rd]);

    // State registers for busy bits and tag pipe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q      <= '0;
            tag_valid_q <= '0;
            for (int i = 0; i < EXE_LATENCY; i++) begin
                tag_rd_q[i] <= '0;
            end
        end else begin
            busy_q      <= busy_d;
            tag_valid_q <= tag_valid_d;
            tag_rd_q    <= tag_rd_d;
        end
    end

endmodule

// File: rtl/issue_stage.sv
// Issue stage: register file read with writeback bypass, hazard-gated issue
// into registered execution inputs, and result writeback from the tag pipe.
module issue_stage
    import issue_stage_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = DEFAULT_REG_ADDR_WIDTH,
    parameter int EXE_LATENCY    = DEFAULT_EXE_LATENCY
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      dec_valid,
    output logic                      dec_ready,
    input  logic [6:0]                dec_instruction_type,
    input  logic [2:0]                dec_funct3,
    input  logic [6:0]                dec_funct7,
    input  logic [20:0]               dec_immediate,
    input  logic [REG_ADDR_WIDTH-1:0] dec_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] dec_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] dec_rd,
    input  logic                      system_stall,
    input  logic [DATA_WIDTH-1:0]     exe_result,
    input  logic                      exe_result_valid,
    output logic [6:0]                instruction_type,
    output logic [2:0]                funct3,
    output logic [6:0]                funct7,
    output logic [20:0]               immediate,
    output logic [DATA_WIDTH-1:0]     data_src1,
    output logic [DATA_WIDTH-1:0]     data_src2,
    output logic                      issue_valid,
    output logic                      wb_orphan
);

    localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;

    logic                      head_valid;
    logic [REG_ADDR_WIDTH-1:0] head_rd;
    logic                      hazard;
    logic                      accept;
    logic                      wb_write;

    logic [DATA_WIDTH-1:0]     regfile_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]     regfile_d [NUM_REGS];
    logic [REG_ADDR_WIDTH-1:0] read_addr [2];
    logic [DATA_WIDTH-1:0]     read_data [2];

    issue_ctrl_t               ctrl_q;
    issue_ctrl_t               ctrl_d;
    logic [DATA_WIDTH-1:0]     data_src1_q;
    logic [DATA_WIDTH-1:0]     data_src1_d;
    logic [DATA_WIDTH-1:0]     data_src2_q;
    logic [DATA_WIDTH-1:0]     data_src2_d;
    logic                      issue_valid_q;
    logic                      issue_valid_d;
    logic                      wb_orphan_q;
    logic                      wb_orphan_d;

    issue_scoreboard #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
        .EXE_LATENCY    (EXE_LATENCY)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .set_valid  (accept),
        .set_rd     (dec_rd),
        .query_rs1  (dec_rs1),
        .query_rs2  (dec_rs2),
        .query_rd   (dec_rd),
        .head_valid (head_valid),
        .head_rd    (head_rd),
        .hazard     (hazard)
    );

    assign dec_ready = !system_stall && !hazard;
    assign accept    = dec_valid && dec_ready;
    assign wb_write  = head_valid && exe_result_valid && head_rd != '0;

    // Read ports: x0 is hardwired to zero; a same-cycle writeback is forwarded.
    assign read_addr[0] = dec_rs1;
    assign read_addr[1] = dec_rs2;
    for (genvar gi = 0; gi < 2; gi++) begin : g_read
        assign read_data[gi] = (read_addr[gi] == '0)                 ? '0 :
                               (wb_write && head_rd == read_addr[gi]) ? exe_result :
                                                                        regfile_q[read_addr[gi]];
    end

    // Register file next state: single writeback port from the tag pipe head.
    always_comb begin
        regfile_d = regfile_q;
        if (wb_write) begin
            regfile_d[head_rd] = exe_result;
        end
    end

    // Issue register next state: load on accept, otherwise drive a NOP.
    always_comb begin
        ctrl_d                  = '0;
        ctrl_d.instruction_type = NOP_INSTR_TYPE;
        data_src1_d             = '0;
        data_src2_d             = '0;
        issue_valid_d           = 1'b0;
        if (accept) begin
            ctrl_d.instruction_type = dec_instruction_type;
            ctrl_d.funct3           = dec_funct3;
            ctrl_d.funct7           = dec_funct7;
            ctrl_d.immediate        = dec_immediate;
            data_src1_d             = read_data[0];
            data_src2_d             = read_data[1];
            issue_valid_d           = 1'b1;
        end
        wb_orphan_d = wb_orphan_q || (!head_valid && exe_result_valid);
    end

    // State registers for the register file, issue registers and orphan flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regfile_q[i] <= '0;
            end
            ctrl_q        <= '0;
            data_src1_q   <= '0;
            data_src2_q   <= '0;
            issue_valid_q <= 1'b0;
            wb_orphan_q   <= 1'b0;
        end else begin
            regfile_q     <= regfile_d;
            ctrl_q        <= ctrl_d;
            data_src1_q   <= data_src1_d;
            data_src2_q   <= data_src2_d;
            issue_valid_q <= issue_valid_d;
            wb_orphan_q   <= wb_orphan_d;
        end
    end

    assign instruction_type = ctrl_q.instruction_type;
    assign funct3           = ctrl_q.funct3;
    assign funct7           = ctrl_q.funct7;
    assign immediate        = ctrl_q.immediate;
    assign data_src1        = data_src1_q;
    assign data_src2        = data_src2_q;
    assign issue_valid      = issue_valid_q;
    assign wb_orphan        = wb_orphan_q;

endmodule

// File: tb/tb_issue_stage.sv
// Self-checking bench for issue_stage: an in-flight list with due times acts as
// both the execution unit and the reference model.
module tb_issue_stage;
    import issue_stage_pkg::*;

    localparam int LAT = DEFAULT_EXE_LATENCY;

    logic        clk = 1'b0;
    logic        reset;
    logic        dec_valid;
    logic        dec_ready;
    logic [6:0]  dec_instruction_type;
    logic [2:0]  dec_funct3;
    logic [6:0]  dec_funct7;
    logic [20:0] dec_immediate;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic        system_stall;
    logic [31:0] exe_result;
    logic        exe_result_valid;
    logic [6:0]  instruction_type;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [20:0] immediate;
    logic [31:0] data_src1, data_src2;
    logic        issue_valid;
    logic        wb_orphan;

    always #5 clk = ~clk;

    issue_stage dut (
        .clk                  (clk),
        .reset                (reset),
        .dec_valid            (dec_valid),
        .dec_ready            (dec_ready),
        .dec_instruction_type (dec_instruction_type),
        .dec_funct3           (dec_funct3),
        .dec_funct7           (dec_funct7),
        .dec_immediate        (dec_immediate),
        .dec_rs1              (dec_rs1),
        .dec_rs2              (dec_rs2),
        .dec_rd               (dec_rd),
        .system_stall         (system_stall),
        .exe_result           (exe_result),
        .exe_result_valid     (exe_result_valid),
        .instruction_type     (instruction_type),
        .funct3               (funct3),
        .funct7               (funct7),
        .immediate            (immediate),
        .data_src1            (data_src1),
        .data_src2            (data_src2),
        .issue_valid          (issue_valid),
        .wb_orphan            (wb_orphan)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: architectural registers plus in-flight list.
    logic [31:0] mreg [32];
    int          q_rd  [$];
    int          q_due [$];
    logic [31:0] q_val [$];
    bit          q_ok  [$];
    int          k;
    bit          m_orphan;
    logic [6:0]  e_type;
    logic [2:0]  e_f3;
    logic [6:0]  e_f7;
    logic [20:0] e_imm;
    logic [31:0] e_d1, e_d2;
    bit          e_valid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int due_idx();
        for (int i = 0; i < q_due.size(); i++)
            if (q_due[i] == k + 1) return i;
        return -1;
    endfunction

    // A register is busy when an older instruction targets it and is not retiring now.
    function automatic bit busy_p(input logic [4:0] r);
        if (r == 0) return 1'b0;
        for (int i = 0; i < q_rd.size(); i++)
            if (q_rd[i] == int'(r) && q_due[i] > k + 1) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mreg[i] = '0;
        q_rd.delete(); q_due.delete(); q_val.delete(); q_ok.delete();
        k = 0; m_orphan = 0;
        e_type = '0; e_f3 = '0; e_f7 = '0; e_imm = '0; e_d1 = '0; e_d2 = '0; e_valid = 0;
    endtask

    task automatic check_outputs();
        chk("issue_valid", issue_valid, e_valid);
        chk("instruction_type", instruction_type, e_type);
        chk("funct3", funct3, e_f3);
        chk("funct7", funct7, e_f7);
        chk("immediate", immediate, e_imm);
        chk("data_src1", data_src1, e_d1);
        chk("data_src2", data_src2, e_d2);
        chk("wb_orphan", wb_orphan, m_orphan);
    endtask

    // One clock cycle: drive inputs, check dec_ready, advance model, check registered outputs.
    task automatic step(input bit dv, input logic [6:0] ty, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [20:0] imm,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input bit st, input logic [31:0] val, input bit ok, input bit force_ev,
                        output bit acc);
        int di;
        bit rdy, wr, ev;
        logic [31:0] er, d1, d2;
        di = due_idx();
        if (di >= 0 && q_ok[di]) begin ev = 1; er = q_val[di]; end
        else if (force_ev) begin ev = 1; er = 32'hDEADBEEF; end
        else begin ev = 0; er = $urandom; end
        dec_valid = dv; dec_instruction_type = ty; dec_funct3 = f3; dec_funct7 = f7;
        dec_immediate = imm; dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd;
        system_stall = st; exe_result_valid = ev; exe_result = er;
        #1;
        rdy = !st && !(busy_p(rs1) || busy_p(rs2) || busy_p(rd));
        chk("dec_ready", dec_ready, rdy);
        acc = dv && rdy;
        wr  = (di >= 0) && ev && (q_rd[di] != 0);
        d1  = (rs1 == 0) ? 32'h0 : (wr && q_rd[di] == int'(rs1)) ? er : mreg[rs1];
        d2  = (rs2 == 0) ? 32'h0 : (wr && q_rd[di] == int'(rs2)) ? er : mreg[rs2];
        if (acc) begin
            e_type = ty; e_f3 = f3; e_f7 = f7; e_imm = imm; e_d1 = d1; e_d2 = d2; e_valid = 1;
        end else begin
            e_type = '0; e_f3 = '0; e_f7 = '0; e_imm = '0; e_d1 = '0; e_d2 = '0; e_valid = 0;
        end
        if (di < 0 && ev) m_orphan = 1;
        if (wr) mreg[q_rd[di]] = er;
        if (di >= 0) begin
            q_rd.delete(di); q_due.delete(di); q_val.delete(di); q_ok.delete(di);
        end
        if (acc) begin
            q_rd.push_back(int'(rd)); q_due.push_back(k + 1 + LAT);
            q_val.push_back(val); q_ok.push_back(ok);
        end
        k++;
        @(posedge clk);
        #1;
        check_outputs();
        $display("[TB] t=%0t dv=%0b rs1=%0d rs2=%0d rd=%0d stall=%0b acc=%0b ev=%0b src1=%h src2=%h",
                 $time, dv, rs1, rs2, rd, st, acc, ev, data_src1, data_src2);
    endtask

    task automatic iss(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [31:0] val, input bit ok, input bit st, output bit acc);
        step(1, 7'h33, 3'h5, 7'h20, 21'h1ABCD, rs1, rs2, rd, st, val, ok, 0, acc);
    endtask

    task automatic nop();
        bit a;
        step(0, 7'h0, 3'h0, 7'h0, 21'h0, 5'd0, 5'd0, 5'd0, 0, 32'h0, 0, 0, a);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit a;
        int stalls;
        model_reset();
        reset = 1'b0; dec_valid = 0; dec_instruction_type = '0; dec_funct3 = '0;
        dec_funct7 = '0; dec_immediate = '0; dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
        system_stall = 0; exe_result = '0; exe_result_valid = 0;
        #12;
        check_outputs();
        @(posedge clk); #1;
        reset = 1'b1;

        // Independent back-to-back issue.
        iss(0, 0, 1, 32'h11, 1, 0, a); chk("indep_acc1", a, 1);
        iss(0, 0, 2, 32'h22, 1, 0, a); chk("indep_acc2", a, 1);
        nop(); nop();
        iss(1, 2, 0, 32'h0, 1, 0, a);
        chk("indep_r1", data_src1, 32'h11); chk("indep_r2", data_src2, 32'h22);

        // RAW: one bubble, then bypassed operand.
        iss(0, 0, 3, 32'h5, 1, 0, a);
        stalls = 0;
        for (int i = 0; i < 10; i++) begin
            iss(3, 0, 0, 32'h0, 1, 0, a);
            if (a) break;
            stalls++;
        end
        chk("raw_stalls", stalls, 1); chk("raw_bypass", data_src1, 32'h5);

        // WAW stall, then writes to x0 never stall and never stick.
        iss(0, 0, 4, 32'hA, 1, 0, a);
        stalls = 0;
        for (int i = 0; i < 10; i++) begin
            iss(0, 0, 4, 32'hB, 1, 0, a);
            if (a) break;
            stalls++;
        end
        chk("waw_stalls", stalls, 1);
        iss(0, 0, 0, 32'hFF, 1, 0, a); chk("x0_acc", a, 1);
        nop(); nop();
        iss(0, 4, 0, 32'h0, 1, 0, a);
        chk("x0_reads0", data_src1, 32'h0); chk("waw_final", data_src2, 32'hB);

        // Global stall while rd=5 is in flight.
        iss(0, 0, 5, 32'h55, 1, 0, a); chk("stall_acc", a, 1);
        for (int i = 0; i < 3; i++) begin
            iss(0, 0, 7, 32'h77, 1, 1, a);
            chk("stall_noacc", a, 0); chk("stall_valid", issue_valid, 0);
            chk("stall_type", instruction_type, 0);
        end
        iss(5, 0, 0, 32'h0, 1, 0, a);
        chk("stall_retired", a, 1); chk("stall_r5", data_src1, 32'h55);

        // Result-less uop.
        iss(0, 0, 6, 32'h66, 0, 0, a);
        nop(); nop();
        iss(6, 0, 0, 32'h0, 1, 0, a);
        chk("nores_acc", a, 1); chk("nores_r6", data_src1, 32'h0); chk("nores_orphan", wb_orphan, 0);

        // Randomized traffic on a small register window to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 7'($urandom), 3'($urandom), 7'($urandom),
                 21'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), $urandom_range(0, 9) == 0, $urandom,
                 $urandom_range(0, 9) != 0, 0, a);
        end

        // Reset with two tags in flight.
        nop(); nop();
        iss(0, 0, 1, 32'hAA, 1, 0, a);
        iss(0, 0, 2, 32'hBB, 1, 0, a);
        reset = 1'b0; dec_valid = 0; exe_result_valid = 0;
        #2;
        chk("rst_valid", issue_valid, 0); chk("rst_type", instruction_type, 0);
        chk("rst_src1", data_src1, 0); chk("rst_src2", data_src2, 0);
        chk("rst_imm", immediate, 0); chk("rst_orphan", wb_orphan, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
        check_outputs();
        step(0, 7'h0, 3'h0, 7'h0, 21'h0, 5'd0, 5'd0, 5'd0, 0, 32'h0, 0, 1, a);
        chk("rst_orphan_set", wb_orphan, 1);
        nop(); nop();
        iss(1, 2, 0, 32'h0, 1, 0, a);
        chk("rst_acc", a, 1); chk("rst_r1", data_src1, 32'h0); chk("rst_r2", data_src2, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/issue_stage.md
Name: issue_stage

Overview:
- Operand-fetch/issue stage directly upstream of the execution stage.
- Accepts decoded instructions, reads the 32-entry integer register file and blocks RAW/WAW hazards with a per-register scoreboard.
- Drives registered operands and control fields into execution.
- Tracks each in-flight destination register through a tag pipe aligned to execution latency, and writes the returned result back into the register file.

Parameters:
- DATA_WIDTH, 32, operand/result width (matches `DATA_WIDTH).
- REG_ADDR_WIDTH, 5, register index width; NUM_REGS = 2**REG_ADDR_WIDTH.
- EXE_LATENCY, 2, cycles from issue-register update to the matching exe_result_valid; tag pipe depth (>=1).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- dec_valid  input  1  decoded instruction present.
- dec_ready  output  1  issue can accept this cycle (combinational).
- dec_instruction_type  input  7  opcode class.
- dec_funct3  input  3  funct3.
- dec_funct7  input  7  funct7.
- dec_immediate  input  21  immediate.
- dec_rs1  input  REG_ADDR_WIDTH  source 1 index.
- dec_rs2  input  REG_ADDR_WIDTH  source 2 index.
- dec_rd  input  REG_ADDR_WIDTH  destination index.
- system_stall  input  1  global stall: blocks new issue.
- exe_result  input  DATA_WIDTH  result returned by execution.
- exe_result_valid  input  1  result valid from execution.
- instruction_type  output  7  registered to execution.
- funct3  output  3  registered to execution.
- funct7  output  7  registered to execution.
- immediate  output  21  registered to execution.
- data_src1  output  DATA_WIDTH  registered operand 1.
- data_src2  output  DATA_WIDTH  registered operand 2.
- issue_valid  output  1  issue register holds a live instruction.
- wb_orphan  output  1  sticky: exe_result_valid seen with tag head invalid.

Behaviour:
- Reset (reset=0, async): all outputs 0, register file all 0, busy bits 0, tag pipe invalid, wb_orphan 0. A reset mid-operation discards all in-flight tags; no writeback occurs.
- Register x0 reads 0 always, is never written, and is never marked busy.
- Writeback: the tag pipe head (valid_h, rd_h) is consumed every cycle.
  - If valid_h && exe_result_valid && rd_h != 0: write regfile[rd_h] = exe_result at the clock edge.
  - If valid_h: clear busy[rd_h], whether or not a result arrived (result-less uop).
  - If !valid_h && exe_result_valid: set wb_orphan, no write.
- Read bypass: if a same-cycle writeback targets rs1/rs2 (nonzero), read data = exe_result and that register counts as not busy.
- Hazard: hz = (rs1!=0 && busy'[rs1]) || (rs2!=0 && busy'[rs2]) || (rd!=0 && busy'[rd]), where busy' = busy with the same-cycle writeback clear applied. rs2 is always checked, even for immediate forms; this conservative stall is intended.
- dec_ready = !system_stall && !hz. Accept = dec_valid && dec_ready.
- On accept (edge N):
  - Issue registers load the control fields and read data; issue_valid = 1.
  - Tag pipe tail loads (1, dec_rd).
  - busy[dec_rd] set if nonzero. A set wins over a same-cycle clear of the same index.
- No accept: instruction_type, funct3, funct7, immediate and data_src are driven to 0 (NOP, no valid uop in execution); issue_valid = 0; tail loads (0, 0).
- The tag pipe shifts every cycle regardless of system_stall, because execution does not stall.
- Timing: result of an instruction accepted at edge N is expected at edge N+EXE_LATENCY. A dependent instruction is accepted no earlier than the edge of that writeback cycle (bypass), giving EXE_LATENCY-1 bubble cycles.
- Throughput: 1 instruction/cycle when independent.

Decomposition:
- Shared header (system_param.vh / Execution_param.vh):
  - REG_ADDR_WIDTH, NUM_REGS, EXE_LATENCY.
  - NOP instruction_type encoding (0).
  - ISSUE_TAG_WIDTH = REG_ADDR_WIDTH+1.
- Sub-module issue_scoreboard:
  - Holds busy vector and tag pipe.
  - Inputs: set valid/index, head outputs, rs1/rs2/rd query.
  - Outputs: hazard.
- The register file and issue registers stay in issue_stage and use the `POS_EDGE_FF macro.

Test Plan:
- Reset: assert reset=0 mid-stream with 2 tags in flight, release -> all outputs 0, busy clear, next exe_result_valid raises wb_orphan and leaves the regfile unchanged.
- Independent back-to-back: issue rd=1 then rd=2, exe returns 0x11, 0x22 at N+2, N+3 -> dec_ready stays 1, regfile[1]=0x11, regfile[2]=0x22.
- RAW: issue rd=3 (result 0x5), then rs1=3 -> dec_ready=0 for 1 cycle, accepted on the writeback edge, data_src1=0x5 via bypass.
- WAW plus x0: issue rd=4, then rd=4 -> stalls until first writeback. Issue rd=0 with result 0xFF -> no stall, x0 reads 0.
- system_stall=1 for 3 cycles with rd=5 in flight -> no issue, issue_valid=0, instruction_type=0, tag still retires at N+2 and busy[5] clears.
- Result-less uop: issue rd=6 with exe_result_valid=0 at N+2 -> busy[6] clears, regfile[6] unchanged, wb_orphan stays 0.
